// File: rtl/uart_tx_framer_if.sv
// Handshake bundle between the byte source, the UART framer and the serializer.
// master drives the word and the serializer returns; slave is the framer itself.
interface uart_tx_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Data_Valid;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  ser_data;
  logic                  ser_done;
  logic                  ser_en;
  logic                  TX_OUT;
  logic                  busy;
  logic                  ser_err;

  modport master (
    output Data_Valid, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
    input  ser_en, TX_OUT, busy, ser_err
  );

  modport slave (
    input  Data_Valid, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
    output ser_en, TX_OUT, busy, ser_err
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 8 LSB-first data bits from the serializer, optional parity, stop.
// Optional parity support is compiled in with UART_TX_PARITY_EN.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  uart_tx_framer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       after_data;
  logic       ser_err_q;
  logic       accept;
  logic       tx;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
`else
  logic [DATA_WIDTH+1:0] unused_par_inputs;
  assign unused_par_inputs = {bus.P_DATA, bus.PAR_EN, bus.PAR_TYP};
`endif

  assign accept = bus.Data_Valid && ((state == IDLE) || (state == STOP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      after_data <= 1'b0;
      ser_err_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      after_data <= (state == DATA) && (cnt == 3'd7);

      // A failed completion check outranks the clear from a new word in the same cycle.
      if (after_data && !bus.ser_done)
        ser_err_q <= 1'b1;
      else if (accept)
        ser_err_q <= 1'b0;

      case (state)
        IDLE, STOP: begin
          if (accept) begin
            state     <= START;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= bus.PAR_EN;
            par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
`endif
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          state <= DATA;
          cnt   <= '0;
        end
        DATA: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state <= par_en_q ? PARITY : STOP;
`else
            state <= STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: state <= STOP;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = bus.ser_data;
`ifdef UART_TX_PARITY_EN
      PARITY:  tx = par_bit_q;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign bus.TX_OUT  = tx;
  assign bus.ser_en  = (state == START) || ((state == DATA) && (cnt != 3'd7));
  assign bus.busy    = (state != IDLE);
  assign bus.ser_err = ser_err_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with a behavioural LSB-first serializer model.
// Expected frame layout follows the UART_TX_PARITY_EN setting of the build.
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic clk;
  logic rst;

  uart_tx_framer_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_framer #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] ser_byte;
  logic [2:0] ser_idx;
  logic       kill_done;

  // Serializer: each enabled edge presents the next bit; done rises after the eighth shift.
  always @(posedge clk) begin
    if (rst) begin
      ser_idx      <= '0;
      bus.ser_data <= 1'b0;
      bus.ser_done <= 1'b0;
    end else if (bus.ser_en) begin
      bus.ser_data <= ser_byte[ser_idx];
      ser_idx      <= ser_idx + 3'd1;
      bus.ser_done <= (ser_idx == 3'd7) && !kill_done;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [7:0] d, input logic pe, input logic pt);
    bus.Data_Valid = 1'b1;
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    ser_byte       = d;
  endtask

  // Entered at the negedge on which the word is offered; returns at the STOP-cycle negedge.
  task automatic frame(input string tag, input logic [7:0] d, input logic pe, input logic expar,
                       input logic chain, input logic [7:0] nd, input logic npe, input logic npt);
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    check({tag, " start tx"}, bus.TX_OUT, 1'b0);
    check({tag, " start busy"}, bus.busy, 1'b1);
    check({tag, " start ser_en"}, bus.ser_en, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("%s data%0d tx", tag, k), bus.TX_OUT, d[k]);
      check($sformatf("%s data%0d busy", tag, k), bus.busy, 1'b1);
      check($sformatf("%s data%0d ser_en", tag, k), bus.ser_en, (k != 7));
    end
    if (HAS_PAR && pe) begin
      @(negedge clk);
      check({tag, " parity tx"}, bus.TX_OUT, expar);
      check({tag, " parity busy"}, bus.busy, 1'b1);
    end
    @(negedge clk);
    check({tag, " stop tx"}, bus.TX_OUT, 1'b1);
    check({tag, " stop busy"}, bus.busy, 1'b1);
    check({tag, " stop ser_en"}, bus.ser_en, 1'b0);
    if (chain) offer(nd, npe, npt);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, " idle busy"}, bus.busy, 1'b0);
    check({tag, " idle tx"}, bus.TX_OUT, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    kill_done      = 1'b0;
    ser_byte       = 8'h00;
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", bus.TX_OUT, 1'b1);
    check("reset busy", bus.busy, 1'b0);
    check("reset ser_en", bus.ser_en, 1'b0);
    check("reset ser_err", bus.ser_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset tx", bus.TX_OUT, 1'b1);

    // 0xA5 even: 0,1,0,1,0,0,1,0,1,[0],1
    offer(8'hA5, 1'b1, 1'b0);
    frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    expect_idle("a5_even");
    check("a5_even ser_err", bus.ser_err, 1'b0);

    offer(8'h01, 1'b1, 1'b1);
    frame("01_odd", 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    expect_idle("01_odd");

    offer(8'h03, 1'b1, 1'b1);
    frame("03_odd", 8'h03, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    expect_idle("03_odd");

    // Back-to-back: 0xFF then 0x00, Data_Valid held through STOP
    offer(8'hFF, 1'b1, 1'b0);
    frame("ff_b2b", 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    frame("00_b2b", 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    expect_idle("00_b2b");

    offer(8'h96, 1'b0, 1'b0);
    frame("96_nopar", 8'h96, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    expect_idle("96_nopar");

    // Reset in DATA count 3
    offer(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("abort data%0d tx", k), bus.TX_OUT, ser_byte[k]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort tx", bus.TX_OUT, 1'b1);
    check("abort busy", bus.busy, 1'b0);
    check("abort ser_en", bus.ser_en, 1'b0);
    @(negedge clk);
    check("abort stays idle tx", bus.TX_OUT, 1'b1);
    check("abort stays idle busy", bus.busy, 1'b0);

    offer(8'hC3, 1'b1, 1'b0);
    frame("c3_after_rst", 8'hC3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    expect_idle("c3_after_rst");

    // Serializer never completes
    kill_done = 1'b1;
    offer(8'h5A, 1'b1, 1'b0);
    frame("5a_nodone", 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("nodone ser_err at stop", bus.ser_err, HAS_PAR);
    expect_idle("5a_nodone");
    check("nodone ser_err set", bus.ser_err, 1'b1);
    @(negedge clk);
    check("nodone ser_err sticky", bus.ser_err, 1'b1);
    kill_done = 1'b0;
    offer(8'h81, 1'b0, 1'b0);
    frame("81_clear", 8'h81, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("clear ser_err at stop", bus.ser_err, 1'b0);
    expect_idle("81_clear");
    check("clear ser_err idle", bus.ser_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of data bits per frame; only 8 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Data_Valid, input, 1 bit: a P_DATA word is offered this cycle.
REQ-005 SHALL have port P_DATA, input, 8 bits: the parallel byte to transmit.
REQ-006 SHALL have port PAR_EN, input, 1 bit: 1 appends a parity bit to the frame.
REQ-007 SHALL have port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd.
REQ-008 SHALL have port ser_data, input, 1 bit: the registered bit stream from the downstream serializer.
REQ-009 SHALL have port ser_done, input, 1 bit: the serializer's completion flag.
REQ-010 SHALL have port ser_en, output, 1 bit: the serializer shift enable.
REQ-011 SHALL have port TX_OUT, output, 1 bit: the UART line, idle high.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port ser_err, output, 1 bit: sticky flag, set when the serializer handshake fails.

Function
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-015 SHALL accept Data_Valid only in IDLE or STOP; acceptance at edge T latches PAR_EN, PAR_TYP and parity(P_DATA), then enters START.
REQ-016 SHALL ignore Data_Valid in START, DATA and PARITY, with no queuing.
REQ-017 SHALL drive TX_OUT from state: IDLE=1, START=0, DATA=ser_data, PARITY=parity bit, STOP=1.
REQ-018 SHALL keep START for 1 cycle and DATA for exactly 8 cycles, counted by an internal 3-bit counter reset on entry to DATA.
REQ-019 SHALL drive ser_en combinationally: 1 in START and in DATA counts 0-6, 0 otherwise, so bit k arrives LSB-first in DATA count k.
REQ-020 SHALL transition DATA to PARITY when parity is latched-enabled, otherwise DATA to STOP.
REQ-021 SHALL transition PARITY to STOP after 1 cycle.
REQ-022 SHALL keep STOP for 1 cycle, then go to START if a new word was accepted, else IDLE; back-to-back frames have no idle gap.
REQ-023 SHALL compute the parity bit as the XOR of the 8 latched bits for even parity, and its inverse for odd.
REQ-024 SHALL check ser_done in the first cycle after DATA; if ser_done is 0 there, ser_err SHALL be set from the next cycle on.
REQ-025 SHALL clear ser_err only on reset or on the next accepted Data_Valid; when a clear and a set coincide, the set SHALL win.
REQ-026 SHALL hold busy at 1 in START, DATA, PARITY and STOP, and at 0 in IDLE.
REQ-027 SHALL give a frame length of 11 cycles with parity and 10 without, from START through STOP.

Reset
REQ-028 SHALL, on rst=1 at an edge, set state IDLE, TX_OUT=1, busy=0, ser_err=0, ser_en=0 and clear the counter and latches.
REQ-029 SHALL give reset priority over Data_Valid; reset mid-frame SHALL abort the frame with TX_OUT=1 from the next cycle and no partial stop bit.

Configuration
REQ-030 SHALL, with UART_TX_PARITY_EN defined, implement the PARITY state and honour PAR_EN and PAR_TYP as specified.
REQ-031 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and parity logic, go DATA to STOP always, and ignore PAR_EN and PAR_TYP; the ports SHALL remain.

Verification
REQ-032 SHALL verify: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, then busy=0.
REQ-033 SHALL verify: P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity bit=0; P_DATA=0x03, odd -> parity bit=1.
REQ-034 SHALL verify: Data_Valid held through STOP with 0xFF then 0x00 -> the second START immediately follows the first STOP, with busy continuously 1.
REQ-035 SHALL verify: rst=1 in DATA count 3 -> TX_OUT=1, busy=0, ser_en=0 the next cycle; a subsequent frame is correct.
REQ-036 SHALL verify: ser_done held 0 -> ser_err=1 one cycle after DATA, and cleared by the next accepted Data_Valid.
REQ-037 SHALL verify: build without UART_TX_PARITY_EN, PAR_EN=1 -> a 10-cycle frame with no parity bit.
